// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and word-organised data memory.
// Optional REQ watchdog enabled by defining LSU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a core request; illegal requests fault here
// REQ   | memory request outstanding, waiting for mem_ready_i
// RESP  | one-cycle completion, core released
module load_store_unit #(
  parameter logic [31:0] DM_BASE        = 32'h80000000,
  parameter logic [31:0] DM_LIMIT       = 32'h800003FC,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_nxt;
  logic        lat_we;
  logic [2:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;
  logic        illegal_now;
  logic        accept;
  logic        timeout_hit;
  logic        to_flag;
  logic [31:0] lane;
  logic [31:0] load_ext;

  always_comb begin
    illegal_now = 1'b0;
    if (core_we_i) begin
      if (core_size_i[2] || core_size_i[1:0] == 2'b11) illegal_now = 1'b1;
    end else begin
      if (core_size_i[1:0] == 2'b11 || core_size_i[2:1] == 2'b11) illegal_now = 1'b1;
    end
    if (core_size_i[1:0] == 2'b01 && core_addr_i[0]) illegal_now = 1'b1;
    if (core_size_i[1:0] == 2'b10 && core_addr_i[1:0] != 2'b00) illegal_now = 1'b1;
    if (core_addr_i < DM_BASE || core_addr_i > DM_LIMIT + 32'd3) illegal_now = 1'b1;
  end

  assign accept = (state == IDLE) && core_req_i && !illegal_now;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Down-counter loaded on entry to REQ; terminal count marks the last REQ cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (accept) wd_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
      else if (state == REQ && wd_cnt != '0) wd_cnt <= wd_cnt - 1'b1;
      to_flag <= timeout_hit;
    end
  end

  assign timeout_hit = (state == REQ) && !mem_ready_i && (wd_cnt == '0);
`else
  // No watchdog: REQ waits for mem_ready_i indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign to_flag     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (mem_ready_i || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lane     = mem_rd_i >> {lat_addr[1:0], 3'b000};
    load_ext = lane;
    case (lat_size)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wd    <= '0;
      core_rd_o <= '0;
    end else begin
      if (accept) begin
        lat_we   <= core_we_i;
        lat_size <= core_size_i;
        lat_addr <= core_addr_i;
        lat_wd   <= core_wd_i;
      end
      if (state == REQ && mem_ready_i) begin
        if (!lat_we) core_rd_o <= load_ext;
      end else if (timeout_hit) begin
        core_rd_o <= '0;
      end
    end
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = '0;
    mem_wd_o     = '0;
    core_stall_o = core_req_i && (state != RESP) && !illegal_now;
    fault_o      = ((state == IDLE) && core_req_i && illegal_now) ||
                   ((state == RESP) && to_flag);
    if (state == REQ) begin
      mem_req_o  = 1'b1;
      mem_we_o   = lat_we;
      mem_addr_o = {lat_addr[31:2], 2'b00};
      case (lat_size[1:0])
        2'b00: begin
          mem_be_o = 4'b0001 << lat_addr[1:0];
          mem_wd_o = {4{lat_wd[7:0]}};
        end
        2'b01: begin
          mem_be_o = 4'b0011 << lat_addr[1:0];
          mem_wd_o = {2{lat_wd[15:0]}};
        end
        default: begin
          mem_be_o = 4'b1111;
          mem_wd_o = lat_wd;
        end
      endcase
    end
  end

endmodule
